ud_count_decoder: RTL

UD_COUNT_DECODER -- requirements
Module: ud_count_decoder

---
 rtl/ud_count_pkg.sv | 25 ++
 rtl/ud_step_classify.sv | 34 +++
 rtl/ud_count_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ud_count_pkg.sv
// ud_count_pkg
// Shared definitions for the up/down count decoder:
//   state_e  - FSM state / step classification code
//   DIR_UP, DIR_DOWN - encodings of the dir output
//   RUN_MAX  - saturation value of the run_len counter
//   is_step  - true for the two legal step classifications
package ud_count_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    HOLD  = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;
  localparam logic [3:0] RUN_MAX  = 4'd15;

  function automatic logic is_step(input state_e cls);
    return (cls == UP) || (cls == DOWN);
  endfunction

endpackage

// File: rtl/ud_step_classify.sv
// ud_step_classify
// Purely combinational classifier of one counter transition.
// Ports:
//   prev     - previously sampled counter value
//   count_in - current counter value
//   cls      - HOLD (no change), UP (+1), DOWN (-1) or FAULT (anything else)
// The difference is taken modulo 2^WIDTH, so wrap-around in either
// direction is an ordinary legal step.
module ud_step_classify
  import ud_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output state_e           cls
);

  logic [WIDTH-1:0] delta;

  always_comb begin
    delta = count_in - prev;
    if (delta == '0) begin
      cls = HOLD;
    end else if (delta == WIDTH'(1)) begin
      cls = UP;
    end else if (delta == '1) begin
      cls = DOWN;
    end else begin
      cls = FAULT;
    end
  end

endmodule

// File: rtl/ud_count_decoder.sv
// ud_count_decoder
// Watches an external up/down counter and reports how it moved.
// Ports:
//   clk        - clock, everything updates on the rising edge
//   nrst       - synchronous active-low reset
//   count_in   - counter value, sampled every edge
//   dir        - direction of the last legal step (1 = up, 0 = down)
//   step       - one-cycle pulse per legal +1/-1 step
//   hold       - high while the counter did not change
//   err        - one-cycle pulse per illegal jump
//   err_sticky - latched error flag, cleared only by reset
//   run_len    - consecutive same-direction steps, saturating at 15
//   state      - current FSM state code
// All outputs are registered and describe the sample taken at the
// previous edge.
module ud_count_decoder
  import ud_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir,
  output logic             step,
  output logic             hold,
  output logic             err,
  output logic             err_sticky,
  output logic [3:0]       run_len,
  output logic [2:0]       state
);

  state_e           state_q;
  state_e           state_d;
  state_e           cls;
  logic [WIDTH-1:0] prev;

  logic             dir_d;
  logic             step_d;
  logic             hold_d;
  logic             err_d;
  logic             sticky_d;
  logic [3:0]       run_d;
  logic             step_dir;

  ud_step_classify #(
    .WIDTH    (WIDTH)
  ) u_classify (
    .prev     (prev),
    .count_in (count_in),
    .cls      (cls)
  );

  // State register plus the sample history and registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= INIT;
      prev       <= '0;
      dir        <= DIR_DOWN;
      step       <= 1'b0;
      hold       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      run_len    <= '0;
    end else begin
      state_q    <= state_d;
      prev       <= count_in;
      dir        <= dir_d;
      step       <= step_d;
      hold       <= hold_d;
      err        <= err_d;
      err_sticky <= sticky_d;
      run_len    <= run_d;
    end
  end

  // The first sample after reset only primes prev; afterwards the
  // state simply follows the classification of each sample.
  always_comb begin
    if (state_q == INIT) begin
      state_d = HOLD;
    end else begin
      state_d = cls;
    end
  end

  // Next values of the registered outputs.
  // run_len is only zero after reset or a fault, so a zero count marks
  // the first step of a fresh run and loads 1 whatever dir says.
  always_comb begin
    dir_d    = dir;
    step_d   = 1'b0;
    hold_d   = 1'b0;
    err_d    = 1'b0;
    sticky_d = err_sticky;
    run_d    = run_len;
    step_dir = (cls == UP) ? DIR_UP : DIR_DOWN;

    if (state_q != INIT) begin
      if (is_step(cls)) begin
        step_d = 1'b1;
        dir_d  = step_dir;
        if (run_len == '0 || step_dir != dir) begin
          run_d = 4'd1;
        end else if (run_len != RUN_MAX) begin
          run_d = run_len + 4'd1;
        end
      end else if (cls == HOLD) begin
        hold_d = 1'b1;
      end else begin
        err_d    = 1'b1;
        sticky_d = 1'b1;
        run_d    = '0;
      end
    end
  end

  assign state = state_q;

endmodule
